// File: rtl/core_arf_scoreboard.sv
// In-order issue scoreboard for the 16x16 architectural register file.
// It tracks a busy bit and an owner tag for each register, and allocates writeback tags.
module core_arf_scoreboard #(
   parameter int unsigned ISSUE = 2,
   parameter int unsigned WB    = 2,
   parameter int unsigned TAG_W = 4
) (
   input  logic                   clk_i,
   input  logic                   arst_ni,
   input  logic                   flush_i,
   input  logic [ISSUE-1:0]       iss_valid_i,
   input  logic [ISSUE-1:0]       iss_rs_en_i,
   input  logic [ISSUE-1:0]       iss_rt_en_i,
   input  logic [ISSUE*4-1:0]     iss_rs_i,
   input  logic [ISSUE*4-1:0]     iss_rt_i,
   input  logic [ISSUE-1:0]       iss_rd_en_i,
   input  logic [ISSUE*4-1:0]     iss_rd_i,
   output logic [ISSUE-1:0]       iss_grant_o,
   output logic [ISSUE*TAG_W-1:0] iss_tag_o,
   input  logic [WB-1:0]          wb_en_i,
   input  logic [WB*4-1:0]        wb_addr_i,
   input  logic [WB*TAG_W-1:0]    wb_tag_i,
   output logic [15:0]            busy_o,
   output logic [TAG_W:0]         inflight_o
);

   localparam int unsigned   CW   = TAG_W + 2;
   localparam logic [CW-1:0] MAXF = CW'(2 ** TAG_W);

   logic [15:0]      busy_q, busy_d;
   logic [TAG_W-1:0] owner_q [16];
   logic [TAG_W-1:0] owner_d [16];
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [TAG_W:0]   inflight_q, inflight_d;

   logic [CW-1:0]    n_wr, k, wb_cnt, sum, diff;
   logic [3:0]       rs_j, rt_j, rd_w, wa;
   logic [TAG_W-1:0] wt;
   logic             hazard, cap_ok, prev_ok, g;

   // Grant is an in-order prefix. The capacity check uses only the registered count.
   always_comb begin
      iss_grant_o = '0;
      iss_tag_o   = '0;
      n_wr        = '0;
      k           = '0;
      rs_j        = '0;
      rt_j        = '0;
      hazard      = 1'b0;
      cap_ok      = 1'b0;
      g           = 1'b0;
      prev_ok     = 1'b1;
      for (int unsigned j = 0; j < ISSUE; j++) begin
         rs_j   = iss_rs_i[j*4 +: 4];
         rt_j   = iss_rt_i[j*4 +: 4];
         hazard = (iss_rs_en_i[j] && busy_q[rs_j]) || (iss_rt_en_i[j] && busy_q[rt_j]);
         for (int unsigned i = 0; i < j; i++) begin
            if (iss_valid_i[i] && iss_rd_en_i[i]) begin
               if (iss_rs_en_i[j] && (rs_j == iss_rd_i[i*4 +: 4])) hazard = 1'b1;
               if (iss_rt_en_i[j] && (rt_j == iss_rd_i[i*4 +: 4])) hazard = 1'b1;
            end
         end
         k      = n_wr + CW'(iss_rd_en_i[j]);
         cap_ok = ({1'b0, inflight_q} + k) <= MAXF;
         g      = iss_valid_i[j] && !hazard && cap_ok && prev_ok && !flush_i;
         iss_grant_o[j] = g;
         if (g && iss_rd_en_i[j]) begin
            iss_tag_o[j*TAG_W +: TAG_W] = tag_q + n_wr[TAG_W-1:0];
            n_wr = n_wr + CW'(1);
         end
         prev_ok = g;
      end
   end

   // Writeback releases are applied first, so that a same-cycle reservation overrides them.
   always_comb begin
      busy_d  = busy_q;
      owner_d = owner_q;
      wb_cnt  = '0;
      wa      = '0;
      wt      = '0;
      rd_w    = '0;
      for (int unsigned w = 0; w < WB; w++) begin
         wa = wb_addr_i[w*4 +: 4];
         wt = wb_tag_i[w*TAG_W +: TAG_W];
         if (wb_en_i[w]) begin
            wb_cnt = wb_cnt + CW'(1);
            if (busy_q[wa] && (owner_q[wa] == wt)) busy_d[wa] = 1'b0;
         end
      end
      for (int unsigned j = 0; j < ISSUE; j++) begin
         rd_w = iss_rd_i[j*4 +: 4];
         if (iss_grant_o[j] && iss_rd_en_i[j]) begin
            busy_d[rd_w]  = 1'b1;
            owner_d[rd_w] = iss_tag_o[j*TAG_W +: TAG_W];
         end
      end
      sum        = {1'b0, inflight_q} + n_wr;
      diff       = sum - wb_cnt;
      inflight_d = (sum >= wb_cnt) ? diff[TAG_W:0] : '0;
      tag_d      = tag_q + n_wr[TAG_W-1:0];
      if (flush_i) begin
         busy_d     = '0;
         inflight_d = '0;
         tag_d      = tag_q;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         busy_q     <= '0;
         owner_q    <= '{default: '0};
         tag_q      <= '0;
         inflight_q <= '0;
      end else begin
         busy_q     <= busy_d;
         owner_q    <= owner_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
      end
   end

   assign busy_o     = busy_q;
   assign inflight_o = inflight_q;

endmodule

// File: tb/tb_core_arf_scoreboard.sv
// Directed, table-driven bench for core_arf_scoreboard.
// Expected values are worked out by hand in the vector table and the sequences below.
module tb_core_arf_scoreboard;

   logic        clk = 1'b0;
   logic        arst_ni;
   logic        flush_i;
   logic [1:0]  iss_valid_i, iss_rs_en_i, iss_rt_en_i, iss_rd_en_i;
   logic [7:0]  iss_rs_i, iss_rt_i, iss_rd_i;
   logic [1:0]  iss_grant_o;
   logic [7:0]  iss_tag_o;
   logic [1:0]  wb_en_i;
   logic [7:0]  wb_addr_i, wb_tag_i;
   logic [15:0] busy_o;
   logic [4:0]  inflight_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   core_arf_scoreboard #(.ISSUE(2), .WB(2), .TAG_W(4)) dut (
      .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush_i),
      .iss_valid_i(iss_valid_i), .iss_rs_en_i(iss_rs_en_i), .iss_rt_en_i(iss_rt_en_i),
      .iss_rs_i(iss_rs_i), .iss_rt_i(iss_rt_i), .iss_rd_en_i(iss_rd_en_i), .iss_rd_i(iss_rd_i),
      .iss_grant_o(iss_grant_o), .iss_tag_o(iss_tag_o),
      .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_tag_i(wb_tag_i),
      .busy_o(busy_o), .inflight_o(inflight_o)
   );

   typedef struct {
      logic        flush;
      logic [1:0]  valid, rs_en;
      logic [7:0]  rs;
      logic [1:0]  rt_en;
      logic [7:0]  rt;
      logic [1:0]  rd_en;
      logic [7:0]  rd;
      logic [1:0]  wb_en;
      logic [7:0]  wb_addr, wb_tag;
      logic [1:0]  exp_grant;
      logic [7:0]  exp_tag;
      logic [15:0] exp_busy;
      logic [4:0]  exp_infl;
   } vec_t;

   vec_t vecs [19];

   // A writeback while nothing is in flight is illegal stimulus.
   always @(posedge clk) begin
      if (arst_ni && !flush_i)
         assert ($countones(wb_en_i) <= int'(inflight_o))
            else $error("FAIL wb_underflow: wb=%0d inflight=%0d", $countones(wb_en_i), inflight_o);
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      flush_i     = v.flush;
      iss_valid_i = v.valid;
      iss_rs_en_i = v.rs_en;
      iss_rs_i    = v.rs;
      iss_rt_en_i = v.rt_en;
      iss_rt_i    = v.rt;
      iss_rd_en_i = v.rd_en;
      iss_rd_i    = v.rd;
      wb_en_i     = v.wb_en;
      wb_addr_i   = v.wb_addr;
      wb_tag_i    = v.wb_tag;
   endtask

   // exp_busy/exp_infl give the state before this cycle's edge; grant and tag are combinational.
   task automatic run_vec(input vec_t v, input string nm);
      @(negedge clk);
      drive(v);
      #1;
      chk({nm, " grant"}, 32'(iss_grant_o), 32'(v.exp_grant));
      chk({nm, " tag"}, 32'(iss_tag_o), 32'(v.exp_tag));
      chk({nm, " busy"}, 32'(busy_o), 32'(v.exp_busy));
      chk({nm, " inflight"}, 32'(inflight_o), 32'(v.exp_infl));
   endtask

   initial begin
      vec_t       v;
      logic [3:0] tq;

      //        fl valid  rs_en  rs     rt_en  rt     rd_en  rd     wb_en  wbaddr wbtag  grant  tag    busy      infl
      vecs[0]  = '{0, 2'b11, 2'b10, 8'h50, 2'b00, 8'h00, 2'b01, 8'h03, 2'b00, 8'h00, 8'h00, 2'b11, 8'h00, 16'h0000, 5'd0};
      vecs[1]  = '{0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 16'h0008, 5'd1};
      vecs[2]  = '{0, 2'b01, 2'b01, 8'h03, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 16'h0008, 5'd1};
      vecs[3]  = '{0, 2'b01, 2'b01, 8'h03, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h03, 8'h00, 2'b00, 8'h00, 16'h0008, 5'd1};
      vecs[4]  = '{0, 2'b01, 2'b01, 8'h03, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b01, 8'h00, 16'h0000, 5'd0};
      vecs[5]  = '{0, 2'b11, 2'b10, 8'h20, 2'b00, 8'h00, 2'b01, 8'h02, 2'b00, 8'h00, 8'h00, 2'b01, 8'h01, 16'h0000, 5'd0};
      vecs[6]  = '{0, 2'b01, 2'b01, 8'h02, 2'b00, 8'h00, 2'b00, 8'h00, 2'b10, 8'h20, 8'h10, 2'b00, 8'h00, 16'h0004, 5'd1};
      vecs[7]  = '{0, 2'b01, 2'b01, 8'h02, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b01, 8'h00, 16'h0000, 5'd0};
      vecs[8]  = '{0, 2'b11, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 8'h44, 2'b00, 8'h00, 8'h00, 2'b11, 8'h32, 16'h0000, 5'd0};
      vecs[9]  = '{0, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h04, 2'b01, 8'h04, 8'h02, 2'b01, 8'h04, 16'h0010, 5'd2};
      vecs[10] = '{0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h04, 8'h03, 2'b00, 8'h00, 16'h0010, 5'd2};
      vecs[11] = '{0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h04, 8'h04, 2'b00, 8'h00, 16'h0010, 5'd1};
      vecs[12] = '{0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 16'h0000, 5'd0};
      vecs[13] = '{0, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h06, 2'b00, 8'h00, 8'h00, 2'b01, 8'h05, 16'h0000, 5'd0};
      vecs[14] = '{0, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h06, 2'b01, 8'h06, 8'h05, 2'b01, 8'h06, 16'h0040, 5'd1};
      vecs[15] = '{0, 2'b10, 2'b10, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 16'h0040, 5'd1};
      vecs[16] = '{0, 2'b01, 2'b00, 8'h00, 2'b01, 8'h06, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 16'h0040, 5'd1};
      vecs[17] = '{0, 2'b01, 2'b00, 8'h06, 2'b01, 8'h01, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b01, 8'h00, 16'h0040, 5'd1};
      vecs[18] = '{0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b10, 8'h60, 8'h60, 2'b00, 8'h00, 16'h0040, 5'd1};

      v = '{default: '0};
      drive(v);
      arst_ni = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy_o), 32'h0);
      chk("reset inflight", 32'(inflight_o), 32'h0);
      arst_ni = 1'b1;

      for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Fill all 16 in-flight slots, two writers per cycle; tags run 7..15 then wrap to 0..6.
      tq = 4'd7;
      for (int c = 0; c < 8; c++) begin
         v = '{default: '0};
         v.valid     = 2'b11;
         v.rd_en     = 2'b11;
         v.rd        = {4'(2*c+1), 4'(2*c)};
         v.exp_grant = 2'b11;
         v.exp_tag   = {tq + 4'd1, tq};
         v.exp_busy  = 16'((32'd1 << (2*c)) - 32'd1);
         v.exp_infl  = 5'(2*c);
         run_vec(v, $sformatf("cap%0d", c));
         tq = tq + 4'd2;
      end
      // Full: the writer is blocked.
      v = '{default: '0};
      v.valid = 2'b01; v.rd_en = 2'b01; v.rd = 8'h00;
      v.exp_busy = 16'hFFFF; v.exp_infl = 5'd16;
      run_vec(v, "full_block");
      // Full: a non-writing slot 0 still issues; the writer in slot 1 does not.
      v = '{default: '0};
      v.valid = 2'b11; v.rd_en = 2'b10; v.rd = 8'h10;
      v.exp_grant = 2'b01; v.exp_busy = 16'hFFFF; v.exp_infl = 5'd16;
      run_vec(v, "full_mixed");
      // A same-cycle writeback gives no capacity credit.
      v = '{default: '0};
      v.valid = 2'b01; v.rd_en = 2'b01; v.rd = 8'h00;
      v.wb_en = 2'b01; v.wb_addr = 8'h00; v.wb_tag = 8'h07;
      v.exp_busy = 16'hFFFF; v.exp_infl = 5'd16;
      run_vec(v, "full_wb");
      v = '{default: '0};
      v.valid = 2'b01; v.rd_en = 2'b01; v.rd = 8'h00;
      v.exp_grant = 2'b01; v.exp_tag = 8'h07; v.exp_busy = 16'hFFFE; v.exp_infl = 5'd15;
      run_vec(v, "after_wb");

      // Flush with 16 in flight.
      v = '{default: '0};
      v.flush = 1'b1; v.valid = 2'b01; v.rd_en = 2'b01; v.rd = 8'h05;
      v.exp_busy = 16'hFFFF; v.exp_infl = 5'd16;
      run_vec(v, "flush16");
      // tag_q holds at 8 across the flush.
      v = '{default: '0};
      v.valid = 2'b11; v.rd_en = 2'b11; v.rd = 8'h21;
      v.exp_grant = 2'b11; v.exp_tag = 8'h98;
      run_vec(v, "post_flush");
      v.rd = 8'h43; v.exp_tag = 8'hBA; v.exp_busy = 16'h0006; v.exp_infl = 5'd2;
      run_vec(v, "fill5a");
      v = '{default: '0};
      v.valid = 2'b11; v.rd_en = 2'b01; v.rd = 8'h05; v.rs_en = 2'b10; v.rs = 8'h10;
      v.exp_grant = 2'b01; v.exp_tag = 8'h0C; v.exp_busy = 16'h001E; v.exp_infl = 5'd4;
      run_vec(v, "fill5b");
      v = '{default: '0};
      v.flush = 1'b1; v.valid = 2'b01; v.rd_en = 2'b01; v.rd = 8'h07;
      v.exp_busy = 16'h003E; v.exp_infl = 5'd5;
      run_vec(v, "flush5");
      v = '{default: '0};
      v.valid = 2'b01; v.rd_en = 2'b01; v.rd = 8'h09;
      v.exp_grant = 2'b01; v.exp_tag = 8'h0D;
      run_vec(v, "flush5_after");
      v = '{default: '0};
      v.exp_busy = 16'h0200; v.exp_infl = 5'd1;
      run_vec(v, "pre_reset");

      // Asynchronous reset mid-cycle, well away from any clock edge.
      @(negedge clk);
      iss_valid_i = 2'b01; iss_rd_en_i = 2'b01; iss_rd_i = 8'h0A;
      #1;
      chk("mid grant", 32'(iss_grant_o), 32'h1);
      chk("mid tag", 32'(iss_tag_o), 32'h0E);
      #1 arst_ni = 1'b0;
      #1;
      chk("arst busy", 32'(busy_o), 32'h0);
      chk("arst inflight", 32'(inflight_o), 32'h0);
      chk("arst tag", 32'(iss_tag_o), 32'h0);
      v = '{default: '0};
      drive(v);
      @(negedge clk);
      arst_ni = 1'b1;
      v.valid = 2'b01; v.rd_en = 2'b01; v.rd = 8'h01;
      v.exp_grant = 2'b01; v.exp_tag = 8'h00;
      run_vec(v, "post_reset");
      v = '{default: '0};
      v.exp_busy = 16'h0002; v.exp_infl = 5'd1;
      run_vec(v, "post_reset_state");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_arf_scoreboard.md
# core_arf_scoreboard

In-order issue scoreboard guarding the 16×16-bit architectural register file. It tracks one busy bit and one owner tag per register, and grants issue slots only when they are free of RAW hazards and in-flight capacity is available. It also allocates writeback tags and releases reservations on writeback. It sits between the decode/issue stage and the execution/memory pipes that write the register file.

## Interface
- ISSUE, 2, issue slots per cycle; slot 0 is oldest.
- WB, 2, writeback ports, matching the register-file write ports.
- TAG_W, 4, tag width; maximum in-flight writers is MAXF = 2^TAG_W.
- clk_i  in  1  clock.
- arst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discards all reservations.
- iss_valid_i  in  ISSUE  slot holds an instruction.
- iss_rs_en_i, iss_rt_en_i  in  ISSUE  slot reads rs / rt.
- iss_rs_i, iss_rt_i  in  ISSUE×4  source register numbers.
- iss_rd_en_i  in  ISSUE  slot writes rd.
- iss_rd_i  in  ISSUE×4  destination register.
- iss_grant_o  out  ISSUE  slot issues this cycle (combinational).
- iss_tag_o  out  ISSUE×TAG_W  tag for a granted writer (combinational).
- wb_en_i  in  WB  writeback occurs this cycle.
- wb_addr_i  in  WB×4  register written back.
- wb_tag_i  in  WB×TAG_W  tag of the writer.
- busy_o  out  16  registered busy bits.
- inflight_o  out  TAG_W+1  registered count of outstanding writers.

## Operation
- State:
  - busy_q[16].
  - owner_q[16][TAG_W].
  - tag_q[TAG_W]: next tag to allocate.
  - inflight_q[TAG_W+1].
- Hazard rules for slot j:
  - Blocked if any enabled source equals a register with busy_q=1.
  - Blocked if any enabled source equals iss_rd_i of an earlier slot i<j with iss_valid_i[i] & iss_rd_en_i[i]. There is no intra-group bypass.
  - Same-cycle writeback does not unblock a source; the release is visible next cycle.
- Grants are an in-order prefix. grant[j] = valid[j] & no hazard & capacity ok & (j==0 or grant[j-1]).
- Capacity: let k = number of granted slots with rd_en up to and including j. The slot must satisfy inflight_q + k ≤ MAXF. Only the registered count is used; no same-cycle writeback credit.
- Tag allocation:
  - A granted writer j gets tag_q + (number of granted writers in slots <j), mod 2^TAG_W.
  - tag_q advances by the total number of granted writers, wrapping mod 2^TAG_W.
  - iss_tag_o is 0 for non-granted or non-writing slots.
- Reservation: a granted writer sets busy_q[rd]=1 and owner_q[rd]=its tag.
  - Intra-group WAW to the same rd is allowed; the youngest slot's tag wins.
- Writeback on port w:
  - inflight decrements once per asserted wb_en_i, whether or not the tag matches.
  - busy_q[wb_addr] clears only if busy_q=1 and owner_q==wb_tag. A stale writer superseded by WAW does not clear a newer reservation.
- Same-cycle reserve and writeback on one register: the reservation wins (busy stays 1 with the new owner).
- Two WB ports naming the same register in one cycle: both are compared against owner_q. At most one can match, since tags are unique in flight.
- Flush:
  - On the next edge: busy_q cleared, inflight_q=0, tag_q unchanged.
  - Grants and writebacks in the flush cycle are ignored.
  - iss_grant_o is forced 0 while flush_i=1.
- Writeback with inflight_q=0 is illegal. The implementation saturates at 0, and the bench asserts it never occurs.

## Timing
- Reset values: busy_q=0, owner_q=0, tag_q=0, inflight_q=0, so busy_o=0 and inflight_o=0.
- iss_grant_o and iss_tag_o are combinational from inputs and registered state, within the same cycle.
- Reservation is visible on busy_o and inflight_o one cycle after the grant.
- A dependent instruction issues no earlier than the cycle after the writeback of its source.
- Reset asserted mid-operation clears all state immediately; outputs return to reset values asynchronously.
- inflight_q' = inflight_q + granted writers − asserted wb_en_i. The value never exceeds MAXF.

## Test plan
- Reset, then slot0 writes R3 and slot1 reads R5: both granted, tags 0 and 0 (slot1 does not write); next cycle busy_o=0x0008 and inflight_o=1.
- R3 busy with owner 0, and slot0 reads R3: grant=00; wb_en[0]=1, addr=3, tag=0 in the same cycle still gives grant=00; the next cycle gives grant=01.
- Slot0 writes R2 and slot1 reads R2 in the same group: grant=01; slot1 issues the following cycle only after writeback.
- WAW: R4 reserved with tag 1, then R4 re-reserved with tag 2. Writeback (4, tag 1) leaves busy[4]=1 and inflight decrements. Writeback (4, tag 2) clears busy[4].
- Capacity: issue 16 writers until inflight_o=16, then the next writer's grant=0. One writeback makes it grant the following cycle. The tag wraps from 15 to 0.
- Assert flush_i with 5 in flight and a valid slot: grant=00, then busy_o=0 and inflight_o=0 the next cycle. Asserting arst_ni low mid-stream zeroes all outputs immediately.
